// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: two-road intersection sequencer driven by a 1 Hz square wave.
// Detects OneHz rising edges and steps NS/EW roads through green, yellow and all-red
// phases, each held for a parameterised number of seconds.
// Optional pedestrian request / walk lamp is enabled with the macro PED_REQUEST_EN.
module traffic_light_fsm #(
    parameter int NS_GREEN_SEC  = 10,
    parameter int EW_GREEN_SEC  = 8,
    parameter int YELLOW_SEC    = 3,
    parameter int ALL_RED_SEC   = 1,
    parameter int MIN_GREEN_SEC = 4
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       OneHz,
`ifdef PED_REQUEST_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] phase,
    output logic [7:0] sec_remaining
);

    localparam logic [2:0] S_NS_GREEN  = 3'd0;
    localparam logic [2:0] S_NS_YELLOW = 3'd1;
    localparam logic [2:0] S_ALL_RED_A = 3'd2;
    localparam logic [2:0] S_EW_GREEN  = 3'd3;
    localparam logic [2:0] S_EW_YELLOW = 3'd4;
    localparam logic [2:0] S_ALL_RED_B = 3'd5;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Duration in seconds of a given phase; illegal codes fall back to all-red.
    function automatic logic [7:0] phase_dur(input logic [2:0] s);
        case (s)
            S_NS_GREEN:  phase_dur = 8'(NS_GREEN_SEC);
            S_NS_YELLOW: phase_dur = 8'(YELLOW_SEC);
            S_EW_GREEN:  phase_dur = 8'(EW_GREEN_SEC);
            S_EW_YELLOW: phase_dur = 8'(YELLOW_SEC);
            default:     phase_dur = 8'(ALL_RED_SEC);
        endcase
    endfunction

    // Fixed rotation 0->1->2->3->4->5->0; anything else recovers through ALL_RED_B.
    function automatic logic [2:0] next_phase(input logic [2:0] s);
        case (s)
            S_NS_GREEN:  next_phase = S_NS_YELLOW;
            S_NS_YELLOW: next_phase = S_ALL_RED_A;
            S_ALL_RED_A: next_phase = S_EW_GREEN;
            S_EW_GREEN:  next_phase = S_EW_YELLOW;
            S_EW_YELLOW: next_phase = S_ALL_RED_B;
            S_ALL_RED_B: next_phase = S_NS_GREEN;
            default:     next_phase = S_ALL_RED_B;
        endcase
    endfunction

    logic       r_onehz_d;
    logic [2:0] r_state;
    logic [7:0] r_timer;

    logic       w_tick;
    logic       w_illegal;
    logic       w_is_green;
    logic       w_is_all_red;
    logic       w_ped_pending;
    logic [8:0] w_elapsed;
    logic       w_min_ok;
    logic       w_trunc;
    logic       w_advance;
    logic [2:0] w_next;

    assign w_tick       = OneHz & ~r_onehz_d;
    assign w_illegal    = (r_state > S_ALL_RED_B);
    assign w_is_green   = (r_state == S_NS_GREEN) || (r_state == S_EW_GREEN);
    assign w_is_all_red = (r_state == S_ALL_RED_A) || (r_state == S_ALL_RED_B);

    // Seconds of this phase already served once the current tick is counted.
    assign w_elapsed = {1'b0, phase_dur(r_state)} - {1'b0, r_timer} + 9'd1;
    assign w_min_ok  = (w_elapsed >= 9'(MIN_GREEN_SEC));
    assign w_trunc   = w_tick & w_is_green & w_ped_pending & w_min_ok;
    assign w_advance = (w_tick & (r_timer == 8'd1)) | w_trunc;
    assign w_next    = next_phase(r_state);

    // OneHz history for rising-edge detection; resets high so a divider idling high gives no tick.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_onehz_d <= 1'b1;
        end else begin
            r_onehz_d <= OneHz;
        end
    end

    // Phase register and per-phase second timer; the timer reloads on every transition.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_ALL_RED_B;
            r_timer <= 8'(ALL_RED_SEC);
        end else if (w_illegal) begin
            r_state <= S_ALL_RED_B;
            r_timer <= 8'(ALL_RED_SEC);
        end else if (w_advance) begin
            r_state <= w_next;
            r_timer <= phase_dur(w_next);
        end else if (w_tick) begin
            r_timer <= r_timer - 8'd1;
        end
    end

`ifdef PED_REQUEST_EN
    logic r_ped_pending;
    logic r_walk_armed;

    assign w_ped_pending = r_ped_pending;

    // Sticky pedestrian request plus walk arming; a new request on the clearing edge wins.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ped_pending <= 1'b0;
            r_walk_armed  <= 1'b0;
        end else begin
            r_ped_pending <= ped_req | (r_ped_pending & ~w_trunc);
            if (w_trunc) begin
                r_walk_armed <= 1'b1;
            end else if (w_advance && w_is_all_red) begin
                r_walk_armed <= 1'b0;
            end
        end
    end

    assign walk = r_walk_armed & w_is_all_red;
`else
    // Without the pedestrian feature there is never a pending request.
    assign w_ped_pending = 1'b0;
`endif

    // Lamp decode straight from the phase register so lamps and phase change together.
    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (r_state)
            S_NS_GREEN:  ns_light = LAMP_GREEN;
            S_NS_YELLOW: ns_light = LAMP_YELLOW;
            S_EW_GREEN:  ew_light = LAMP_GREEN;
            S_EW_YELLOW: ew_light = LAMP_YELLOW;
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

    assign phase         = r_state;
    assign sec_remaining = r_timer;

endmodule
